// File: rtl/clint_timer_trap_pkg.sv
// Shared constants for the MEM-stage trap controller and its CLINT timer:
// trap bus bit positions, cause codes, CLINT offsets, stall/flush masks.
package clint_timer_trap_pkg;

  localparam int TRAP_BUS     = 4;
  localparam int TRAP_ECALL   = 0;
  localparam int TRAP_EBREAK  = 1;
  localparam int TRAP_MRET    = 2;
  localparam int TRAP_ILLEGAL = 3;

  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_EBREAK  = 4'd3;
  localparam logic [3:0] CAUSE_ECALL   = 4'd11;
  localparam logic [3:0] CAUSE_MSI     = 4'd3;
  localparam logic [3:0] CAUSE_MTI     = 4'd7;

  localparam logic [15:0] CLINT_MSIP     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP = 16'h4000;
  localparam logic [15:0] CLINT_MTIME    = 16'hBFF8;

  // bit 0 = PC ... bit 5 = WB
  localparam logic [5:0] RST_STALL      = 6'b000000;
  localparam logic [5:0] RST_FLUSH      = 6'b011111;
  localparam logic [5:0] RAM_STALL      = 6'b001111;
  localparam logic [5:0] RAM_FLUSH      = 6'b010000;
  localparam logic [5:0] TRAP_STALL     = 6'b000001;
  localparam logic [5:0] TRAP_FLUSH     = 6'b001110;
  localparam logic [5:0] JUMP_STALL     = 6'b000000;
  localparam logic [5:0] JUMP_FLUSH     = 6'b000110;
  localparam logic [5:0] LOAD_USE_STALL = 6'b000011;
  localparam logic [5:0] LOAD_USE_FLUSH = 6'b000100;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MSTATUS_MPP  = 11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENTER  = 2'd1,
    ST_RETURN = 2'd2
  } trap_state_t;

  // Byte-lane merge used by every CLINT register write.
  function automatic logic [63:0] byte_merge(input logic [63:0] old_val,
                                             input logic [63:0] wdata,
                                             input logic [7:0]  wstrb);
    logic [63:0] res;
    res = old_val;
    for (int i = 0; i < 8; i++) begin
      if (wstrb[i]) res[i*8 +: 8] = wdata[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_timer_trap_mtimer.sv
// CLINT timer block: prescaler, mtime, mtimecmp, msip, MMIO decode and the
// registered MTIP/MSIP interrupt lines.
module clint_timer_trap_mtimer
  import clint_timer_trap_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mmio_valid_i,
  input  logic        mmio_we_i,
  input  logic [15:0] mmio_addr_i,
  input  logic [63:0] mmio_wdata_i,
  input  logic [7:0]  mmio_wstrb_i,
  output logic [63:0] mmio_rdata_o,
  output logic        mmio_ready_o,
  output logic        mtip_o,
  output logic        msip_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] presc_q;
  logic [63:0]   mtime_q;
  logic [63:0]   mtimecmp_q;
  logic          msip_q;
  logic          accept;
  logic          wr_msip;
  logic          wr_mtimecmp;
  logic          wr_mtime;
  logic          tick;
  logic [63:0]   rd_mux;

  // A new request is only taken once the previous response has retired.
  assign accept      = mmio_valid_i & ~mmio_ready_o;
  assign wr_msip     = accept & mmio_we_i & (mmio_addr_i == CLINT_MSIP);
  assign wr_mtimecmp = accept & mmio_we_i & (mmio_addr_i == CLINT_MTIMECMP);
  assign wr_mtime    = accept & mmio_we_i & (mmio_addr_i == CLINT_MTIME);
  assign tick        = (presc_q == PW'(TICK_DIV - 1));

  // Prescaler and mtime; a software write to mtime wins over the tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      mtime_q <= '0;
    end else if (wr_mtime) begin
      presc_q <= '0;
      mtime_q <= byte_merge(mtime_q, mmio_wdata_i, mmio_wstrb_i);
    end else if (tick) begin
      presc_q <= '0;
      mtime_q <= mtime_q + 64'd1;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  // Software-visible compare value and software interrupt bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
    end else begin
      if (wr_mtimecmp) mtimecmp_q <= byte_merge(mtimecmp_q, mmio_wdata_i, mmio_wstrb_i);
      if (wr_msip && mmio_wstrb_i[0]) msip_q <= mmio_wdata_i[0];
    end
  end

  // Registered timer compare.
  always_ff @(posedge clk) begin
    if (rst) mtip_o <= 1'b0;
    else     mtip_o <= (mtime_q >= mtimecmp_q);
  end

  assign msip_o = msip_q;

  // Read decode; unmapped offsets read zero.
  always_comb begin
    rd_mux = '0;
    case (mmio_addr_i)
      CLINT_MSIP:     rd_mux = {63'd0, msip_q};
      CLINT_MTIMECMP: rd_mux = mtimecmp_q;
      CLINT_MTIME:    rd_mux = mtime_q;
      default:        rd_mux = '0;
    endcase
  end

  // Single-cycle response with read data on the ready cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mmio_ready_o <= 1'b0;
      mmio_rdata_o <= '0;
    end else begin
      mmio_ready_o <= accept;
      mmio_rdata_o <= (accept && !mmio_we_i) ? rd_mux : '0;
    end
  end

endmodule

// File: rtl/clint_timer_trap.sv
// Machine-mode trap controller in the MEM stage: prioritises interrupts and
// exceptions, sequences trap entry / mret, and drives CSR writes, the PC
// redirect and the pipeline stall/flush masks.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for an accepted trap or mret (deferred on RAM stall)
// ST_ENTER  | one cycle: mepc/mcause/mtval/mstatus writes, redirect to mtvec
// ST_RETURN | one cycle: mstatus write, redirect to mepc
module clint_timer_trap
  import clint_timer_trap_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int TICK_DIV = 1,
  parameter int NSTAGE   = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [XLEN-1:0]     pc_i,
  input  logic [31:0]         inst_data_i,
  input  logic                inst_valid_i,
  input  logic [TRAP_BUS-1:0] trap_bus_i,
  input  logic                ram_stall_valid_if_i,
  input  logic                ram_stall_valid_mem_i,
  input  logic                load_use_valid_id_i,
  input  logic                jump_valid_ex_i,
  input  logic [XLEN-1:0]     csr_mstatus_readdata_i,
  input  logic [XLEN-1:0]     csr_mie_readdata_i,
  input  logic [XLEN-1:0]     csr_mepc_readdata_i,
  input  logic [XLEN-1:0]     csr_mtvec_readdata_i,
  output logic [XLEN-1:0]     csr_mstatus_writedata_o,
  output logic [XLEN-1:0]     csr_mepc_writedata_o,
  output logic [XLEN-1:0]     csr_mcause_writedata_o,
  output logic [XLEN-1:0]     csr_mtval_writedata_o,
  output logic                csr_mstatus_write_valid_o,
  output logic                csr_mepc_write_valid_o,
  output logic                csr_mcause_write_valid_o,
  output logic                csr_mtval_write_valid_o,
  output logic [XLEN-1:0]     mip_o,
  input  logic                mmio_valid_i,
  input  logic                mmio_we_i,
  input  logic [15:0]         mmio_addr_i,
  input  logic [63:0]         mmio_wdata_i,
  input  logic [7:0]          mmio_wstrb_i,
  output logic [63:0]         mmio_rdata_o,
  output logic                mmio_ready_o,
  output logic [XLEN-1:0]     clint_pc_o,
  output logic                clint_pc_valid_o,
  output logic [NSTAGE-1:0]   stall_o,
  output logic [NSTAGE-1:0]   flush_o
);

  trap_state_t     state_q, state_d;
  logic            mtip, msip;
  logic            irq_timer, irq_soft, irq_take;
  logic            exc_raw, inst_exc, can_accept;
  logic            take_trap, take_mret;
  logic [3:0]      cause;
  logic [XLEN-1:0] tval, mcause_val, target, enter_mstatus, ret_mstatus;
  logic            unused_mie;

  clint_timer_trap_mtimer #(.TICK_DIV(TICK_DIV)) u_mtimer (
    .clk          (clk),
    .rst          (rst),
    .mmio_valid_i (mmio_valid_i),
    .mmio_we_i    (mmio_we_i),
    .mmio_addr_i  (mmio_addr_i),
    .mmio_wdata_i (mmio_wdata_i),
    .mmio_wstrb_i (mmio_wstrb_i),
    .mmio_rdata_o (mmio_rdata_o),
    .mmio_ready_o (mmio_ready_o),
    .mtip_o       (mtip),
    .msip_o       (msip)
  );

  assign mip_o      = {{(XLEN-8){1'b0}}, mtip, 3'b000, msip, 3'b000};
  assign unused_mie = &{1'b0, csr_mie_readdata_i};

  // An instruction that is itself trapping blocks the interrupt, so the
  // exception is taken and the interrupt stays pending for a later slot.
  assign exc_raw    = trap_bus_i[TRAP_ILLEGAL] | trap_bus_i[TRAP_EBREAK] | trap_bus_i[TRAP_ECALL];
  assign inst_exc   = inst_valid_i & exc_raw;
  assign irq_timer  = csr_mie_readdata_i[7] & mtip;
  assign irq_soft   = csr_mie_readdata_i[3] & msip;
  assign irq_take   = csr_mstatus_readdata_i[MSTATUS_MIE] & (irq_timer | irq_soft)
                      & inst_valid_i & ~exc_raw;
  assign can_accept = (state_q == ST_IDLE) & ~ram_stall_valid_mem_i & ~ram_stall_valid_if_i;
  assign take_trap  = can_accept & (irq_take | inst_exc);
  assign take_mret  = can_accept & inst_valid_i & trap_bus_i[TRAP_MRET] & ~irq_take & ~inst_exc;

  // Cause, tval, mstatus images and redirect target for the accepted source.
  always_comb begin
    cause = CAUSE_ECALL;
    tval  = '0;
    if (irq_take)                       cause = irq_timer ? CAUSE_MTI : CAUSE_MSI;
    else if (trap_bus_i[TRAP_ILLEGAL]) begin
      cause = CAUSE_ILLEGAL;
      tval  = XLEN'(inst_data_i);
    end else if (trap_bus_i[TRAP_EBREAK]) begin
      cause = CAUSE_EBREAK;
      tval  = pc_i;
    end
    mcause_val = irq_take ? {1'b1, (XLEN-1)'(cause)} : XLEN'(cause);
    target     = {csr_mtvec_readdata_i[XLEN-1:2], 2'b00};
    if (irq_take && csr_mtvec_readdata_i[1:0] == 2'b01)
      target = target + XLEN'({cause, 2'b00});
    enter_mstatus = csr_mstatus_readdata_i;
    enter_mstatus[MSTATUS_MPIE]            = csr_mstatus_readdata_i[MSTATUS_MIE];
    enter_mstatus[MSTATUS_MIE]             = 1'b0;
    enter_mstatus[MSTATUS_MPP+1:MSTATUS_MPP] = 2'b11;
    ret_mstatus = csr_mstatus_readdata_i;
    ret_mstatus[MSTATUS_MIE]               = csr_mstatus_readdata_i[MSTATUS_MPIE];
    ret_mstatus[MSTATUS_MPIE]              = 1'b1;
    ret_mstatus[MSTATUS_MPP+1:MSTATUS_MPP] = 2'b11;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state: ENTER/RETURN last exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (take_trap)      state_d = ST_ENTER;
        else if (take_mret) state_d = ST_RETURN;
      end
      ST_ENTER:  state_d = ST_IDLE;
      ST_RETURN: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // CSR write and redirect registers, loaded on the accept edge so they are
  // presented during the ENTER/RETURN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      csr_mstatus_writedata_o   <= '0;
      csr_mepc_writedata_o      <= '0;
      csr_mcause_writedata_o    <= '0;
      csr_mtval_writedata_o     <= '0;
      csr_mstatus_write_valid_o <= 1'b0;
      csr_mepc_write_valid_o    <= 1'b0;
      csr_mcause_write_valid_o  <= 1'b0;
      csr_mtval_write_valid_o   <= 1'b0;
      clint_pc_o                <= '0;
      clint_pc_valid_o          <= 1'b0;
    end else begin
      csr_mstatus_write_valid_o <= 1'b0;
      csr_mepc_write_valid_o    <= 1'b0;
      csr_mcause_write_valid_o  <= 1'b0;
      csr_mtval_write_valid_o   <= 1'b0;
      clint_pc_valid_o          <= 1'b0;
      if (take_trap) begin
        csr_mstatus_writedata_o   <= enter_mstatus;
        csr_mepc_writedata_o      <= pc_i;
        csr_mcause_writedata_o    <= mcause_val;
        csr_mtval_writedata_o     <= tval;
        csr_mstatus_write_valid_o <= 1'b1;
        csr_mepc_write_valid_o    <= 1'b1;
        csr_mcause_write_valid_o  <= 1'b1;
        csr_mtval_write_valid_o   <= 1'b1;
        clint_pc_o                <= target;
        clint_pc_valid_o          <= 1'b1;
      end else if (take_mret) begin
        csr_mstatus_writedata_o   <= ret_mstatus;
        csr_mstatus_write_valid_o <= 1'b1;
        clint_pc_o                <= csr_mepc_readdata_i;
        clint_pc_valid_o          <= 1'b1;
      end
    end
  end

  // Hazard masks, first match wins.
  always_comb begin
    stall_o = '0;
    flush_o = '0;
    if (rst) begin
      stall_o = NSTAGE'(RST_STALL);
      flush_o = NSTAGE'(RST_FLUSH);
    end else if (ram_stall_valid_mem_i || ram_stall_valid_if_i) begin
      stall_o = NSTAGE'(RAM_STALL);
      flush_o = NSTAGE'(RAM_FLUSH);
    end else if (state_q != ST_IDLE) begin
      stall_o = NSTAGE'(TRAP_STALL);
      flush_o = NSTAGE'(TRAP_FLUSH);
    end else if (jump_valid_ex_i) begin
      stall_o = NSTAGE'(JUMP_STALL);
      flush_o = NSTAGE'(JUMP_FLUSH);
    end else if (load_use_valid_id_i) begin
      stall_o = NSTAGE'(LOAD_USE_STALL);
      flush_o = NSTAGE'(LOAD_USE_FLUSH);
    end
  end

endmodule
